// File: rtl/sz_pkg.sv
// Shared types and widths for the SZ inner decoder: predictor codes, stream widths
// and the reserved-quant-code test used by the optional decode checker.
package sz_pkg;

  localparam int DATA_W     = 32;
  localparam int QUANT_W    = 16;
  localparam int QUANT_BITS = 14;

  typedef enum logic [1:0] {
    SZ_CODE_UNPRED = 2'd0,
    SZ_CODE_ORDER0 = 2'd1,
    SZ_CODE_LINEAR = 2'd2,
    SZ_CODE_QUAD   = 2'd3
  } sz_code_e;

  // A quant word is malformed when its spare top bits are set or it carries the reserved code 0.
  function automatic logic quant_reserved(input logic [QUANT_W-1:0] q);
    return (q[QUANT_W-1:QUANT_BITS] != '0) || (q[QUANT_BITS-1:0] == '0);
  endfunction

endpackage

// File: rtl/sz_dec_predictor.sv
// Combinational predict + reconstruct: picks the predictor from the code, then adds the
// dequantised correction (q - RADIUS) * 2*EB with int32 wrap-around.
module sz_dec_predictor
  import sz_pkg::*;
#(
  parameter int EB     = 4,
  parameter int RADIUS = 8192
) (
  input  sz_code_e                code_i,
  input  logic [QUANT_BITS-1:0]   q_i,
  input  logic [DATA_W-1:0]       unpred_i,
  input  logic [DATA_W-1:0]       x1_i,
  input  logic [DATA_W-1:0]       x2_i,
  input  logic [DATA_W-1:0]       x3_i,
  output logic [DATA_W-1:0]       x_o
);

  localparam int WIDE = DATA_W + 2;
  localparam logic signed [WIDE-1:0] RADIUS_W = WIDE'(RADIUS);
  localparam logic signed [WIDE-1:0] STEP_W   = WIDE'(2 * EB);

  logic [DATA_W-1:0]      pred;
  logic signed [WIDE-1:0] q_off;
  logic signed [WIDE-1:0] corr;
  logic signed [WIDE-1:0] sum;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    pred = '0;
    unique case (code_i)
      SZ_CODE_UNPRED: pred = '0;
      SZ_CODE_ORDER0: pred = x1_i;
      SZ_CODE_LINEAR: pred = (x1_i << 1) - x2_i;
      SZ_CODE_QUAD:   pred = x1_i + (x1_i << 1) - x2_i - (x2_i << 1) + x3_i;
    endcase
  end

  assign q_off = $signed({{(WIDE - QUANT_BITS){1'b0}}, q_i}) - RADIUS_W;
  assign corr  = q_off * STEP_W;
  assign sum   = $signed({{2{pred[DATA_W-1]}}, pred}) + corr;

  assign x_o = (code_i == SZ_CODE_UNPRED) ? unpred_i : sum[DATA_W-1:0];

endmodule

// File: rtl/sz_inner_dec.sv
// SZ inner decoder top: three-stream handshake, 3-deep predictor history with per-block clear,
// one-entry output register. Optional sticky decode-error checker under SZ_INNER_DEC_CHECK_EN.
module sz_inner_dec
  import sz_pkg::*;
#(
  parameter int EB        = 4,
  parameter int RADIUS    = 8192,
  parameter int BLOCK_LEN = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         code_in,
  input  logic               code_valid,
  output logic               code_ready,
  input  logic [QUANT_W-1:0] quant_in,
  input  logic               quant_valid,
  output logic               quant_ready,
  input  logic [DATA_W-1:0]  unpred_in,
  input  logic               unpred_valid,
  output logic               unpred_ready,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               err
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_LEN - 1);

  sz_code_e          code;
  logic              is_unpred;
  logic              sel_valid;
  logic              fire;
  logic              blk_end;
  logic [DATA_W-1:0] x;

  logic [DATA_W-1:0] x1_q, x1_d;
  logic [DATA_W-1:0] x2_q, x2_d;
  logic [DATA_W-1:0] x3_q, x3_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;

  assign code      = sz_code_e'(code_in);
  assign is_unpred = (code == SZ_CODE_UNPRED);
  assign sel_valid = is_unpred ? unpred_valid : quant_valid;
  assign fire      = !rst && code_valid && sel_valid && (!valid_q || data_out_ready);
  assign blk_end   = (blk_cnt_q == BLK_LAST);

  // Only the stream the code selects is consumed; the other keeps its word for a later code.
  assign code_ready   = fire;
  assign quant_ready  = fire && !is_unpred;
  assign unpred_ready = fire && is_unpred;

  sz_dec_predictor #(
    .EB     (EB),
    .RADIUS (RADIUS)
  ) u_predictor (
    .code_i   (code),
    .q_i      (quant_in[QUANT_BITS-1:0]),
    .unpred_i (unpred_in),
    .x1_i     (x1_q),
    .x2_i     (x2_q),
    .x3_i     (x3_q),
    .x_o      (x)
  );

  always_comb begin
    x1_d      = x1_q;
    x2_d      = x2_q;
    x3_d      = x3_q;
    data_d    = data_q;
    valid_d   = valid_q;
    blk_cnt_d = blk_cnt_q;

    if (data_out_ready) valid_d = 1'b0;

    if (fire) begin
      data_d  = x;
      valid_d = 1'b1;
      // The last sample of a block empties the history so the next block predicts from zero.
      if (blk_end) begin
        x1_d      = '0;
        x2_d      = '0;
        x3_d      = '0;
        blk_cnt_d = '0;
      end else begin
        x3_d      = x2_q;
        x2_d      = x1_q;
        x1_d      = x;
        blk_cnt_d = blk_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: history and data_out have architecturally visible reset values, so the datapath
    // registers are reset along with the control bits rather than left uninitialised.
    if (rst) begin
      x1_q      <= '0;
      x2_q      <= '0;
      x3_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      blk_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      x3_q      <= x3_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;

`ifdef SZ_INNER_DEC_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q || (fire && !is_unpred && quant_reserved(quant_in));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_quant_hi;
  assign unused_quant_hi = ^quant_in[QUANT_W-1:QUANT_BITS];
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sz_inner_dec.sv
// Scoreboard bench for sz_inner_dec: a driver computes expected samples from an int32
// history-queue model and pushes them; an independent monitor pops and compares on output handshakes.
module tb_sz_inner_dec;

  localparam int EB        = 4;
  localparam int RADIUS    = 8192;
  localparam int BLOCK_LEN = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  code_in;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] quant_in;
  logic        quant_valid;
  logic        quant_ready;
  logic [31:0] unpred_in;
  logic        unpred_valid;
  logic        unpred_ready;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        err;

  always #5 clk = ~clk;

  sz_inner_dec #(
    .EB        (EB),
    .RADIUS    (RADIUS),
    .BLOCK_LEN (BLOCK_LEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .code_in        (code_in),
    .code_valid     (code_valid),
    .code_ready     (code_ready),
    .quant_in       (quant_in),
    .quant_valid    (quant_valid),
    .quant_ready    (quant_ready),
    .unpred_in      (unpred_in),
    .unpred_valid   (unpred_valid),
    .unpred_ready   (unpred_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .err            (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];

  // Reference model: most recent sample first, at most three, emptied at each block boundary.
  int          hist[$];
  int          blk_n  = 0;
  bit          ov_m   = 1'b0;
  logic [31:0] last_m = '0;
  bit          err_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int h(input int i);
    return (i < hist.size()) ? hist[i] : 0;
  endfunction

  function automatic int model_x(input int c, input int q, input int u);
    int p;
    case (c)
      0:       return u;
      1:       p = h(0);
      2:       p = 2 * h(0) - h(1);
      default: p = 3 * h(0) - 3 * h(1) + h(2);
    endcase
    return p + (q - RADIUS) * 2 * EB;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    blk_n  = 0;
    ov_m   = 1'b0;
    last_m = '0;
    err_m  = 1'b0;
  endtask

  task automatic drive(input bit cv, input logic [1:0] c, input bit qv, input logic [15:0] q,
                       input bit uv, input logic [31:0] u, input bit rdy);
    code_valid     = cv;
    code_in        = c;
    quant_valid    = qv;
    quant_in       = q;
    unpred_valid   = uv;
    unpred_in      = u;
    data_out_ready = rdy;
  endtask

  // Called on a negedge with inputs already driven; checks outputs, advances the model over
  // the next posedge and returns on the following negedge.
  task automatic step();
    bit fire_m;
    bit is_q;
    int x;
    #2;
    is_q   = (code_in != 2'd0);
    fire_m = !rst && code_valid && (is_q ? quant_valid : unpred_valid) && (!ov_m || data_out_ready);
    check("code_ready", code_ready, fire_m);
    check("quant_ready", quant_ready, fire_m && is_q);
    check("unpred_ready", unpred_ready, fire_m && !is_q);
    check("data_out_valid", data_out_valid, ov_m);
    check("data_out_hold", data_out, last_m);
    check("err", err, err_m);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (fire_m) begin
        x = model_x(int'(code_in), int'(quant_in[13:0]), int'(unpred_in));
        exp_q.push_back(32'(x));
        last_m = 32'(x);
        ov_m   = 1'b1;
`ifdef SZ_INNER_DEC_CHECK_EN
        if (is_q && (quant_in[15:14] != 2'b00 || quant_in[13:0] == 14'd0)) err_m = 1'b1;
`endif
        hist.push_front(x);
        if (hist.size() > 3) void'(hist.pop_back());
        blk_n++;
        if (blk_n == BLOCK_LEN) begin
          hist.delete();
          blk_n = 0;
        end
      end else if (data_out_ready) begin
        ov_m = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] c, input int q, input logic [31:0] u);
    drive(1'b1, c, 1'b1, 16'(q), 1'b1, u, 1'b1);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b1);
      step();
    end
  endtask

  // Monitor: an output transfer happens on the posedge following a cycle with valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %08h with nothing expected at %0t", data_out, $time);
        end else begin
          check("data_out", data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    idle(1);

    // Directed: unpredictable, order-0 with zero and +1 correction.
    send(2'd0, 0, 32'h3e702c81);
    check("t1_unpred", data_out, 32'h3e702c81);
    send(2'd1, 8192, 32'h0);
    check("t1_order0", data_out, 32'h3e702c81);
    send(2'd1, 8193, 32'h0);
    check("t1_order0_p1", data_out, 32'h3e702c89);

    // Linear then quadratic predictors.
    send(2'd2, 8190, 32'h0);
    check("t2_linear", data_out, 32'h3e702c81);
    send(2'd3, 8192, 32'h0);

    // Output stall with every stream valid: nothing may be consumed.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, 1'b1, 16'd8192, 1'b1, 32'hdeadbeef, 1'b0);
      step();
    end
    send(2'd1, 8192, 32'h0);

    // Randomised traffic with partial valids and back-pressure.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] q;
      q = 16'(RADIUS - 32 + int'($urandom_range(0, 64)));
      if ($urandom_range(0, 15) == 0) q = 16'($urandom);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, q,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
      step();
    end

    // Reset while an output is being held.
    drive(1'b1, 2'd0, 1'b1, 16'd8192, 1'b1, 32'h12345678, 1'b0);
    step();
    step();
    check("t5_held_valid", data_out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 16'd0, 1'b0, 32'd0, 1'b0);
    #2;
    check("t5_valid_cleared", data_out_valid, 1'b0);
    check("t5_data_cleared", data_out, 32'h0);
    step();
    send(2'd0, 0, 32'h3e702c81);
    send(2'd1, 8192, 32'h0);
    send(2'd1, 8193, 32'h0);
    check("t5_restart", data_out, 32'h3e702c89);

    // Block edge: fill the remaining five slots of the block, then order-0 must see empty history.
    for (int i = 0; i < 5; i++) send(2'd0, 0, $urandom | 32'h1);
    send(2'd1, 8192, 32'h0);
    check("t4_block_clear", data_out, 32'h0);

    // Reserved quant code and unused-stream garbage on an unpredictable code.
    send(2'd1, 0, 32'h0);
`ifdef SZ_INNER_DEC_CHECK_EN
    check("t6_err_set", err, 1'b1);
`else
    check("t6_err_tied", err, 1'b0);
`endif
    send(2'd0, 32'hffff, 32'h55aa55aa);
    idle(4);
`ifdef SZ_INNER_DEC_CHECK_EN
    check("t6_err_sticky", err, 1'b1);
`else
    check("t6_err_still0", err, 1'b0);
`endif
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
